// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: definitions shared by the UART transmit arbiter slice.
//   UART_DATA_W : width of one transmitted byte
//   arb_state_t : arbiter FSM state encoding
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-producer and transmitter signals of the arbiter.
//   req / req_data : per-requester level request and its byte (requester i at [8i+7:8i])
//   ack            : one-hot pulse, the byte of requester i was taken
//   tx_data_in     : byte presented to UART_TXer.data_in
//   tx_en_data_in  : one-cycle launch strobe to UART_TXer.en_data_in
//   tx_rdy         : UART_TXer.rdy, high while the transmitter is idle
// modport master is the arbiter side, modport slave is the environment side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]             req;
  logic [UART_DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             ack;
  logic [UART_DATA_W-1:0]       tx_data_in;
  logic                         tx_en_data_in;
  logic                         tx_rdy;

  modport master (
    input  req, req_data, tx_rdy,
    output ack, tx_data_in, tx_en_data_in
  );

  modport slave (
    output req, req_data, tx_rdy,
    input  ack, tx_data_in, tx_en_data_in
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : request vector
//   ptr   : index of the most recently granted requester
//   valid : at least one request is pending
//   idx   : winner, first set request searching upward from ptr+1 (wrapping)
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       idx
);

  // Offsets 1..N_REQ visit ptr+1 first and ptr itself last, so the
  // previous winner only wins again when nobody else is asking.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!valid && req[(int'(ptr) + off) % N_REQ]) begin
        valid = 1'b1;
        idx   = 3'((int'(ptr) + off) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TXer among N_REQ byte producers.
//   clk        : system clock, rising edge
//   res        : asynchronous active-high reset
//   bus        : requester and transmitter signals (uart_tx_arbiter_if.master)
//   busy       : high whenever the FSM is not in IDLE
//   last_grant : index of the most recently granted requester
//   guard_err  : sticky, tx_rdy did not fall within GUARD cycles of a launch
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GUARD = 16
) (
  input  logic                    clk,
  input  logic                    res,
  uart_tx_arbiter_if.master       bus,
  output logic                    busy,
  output logic [2:0]              last_grant,
  output logic                    guard_err
);

  localparam int GW = $clog2(GUARD + 1);

  arb_state_t             state;
  logic [GW-1:0]          guard_cnt;
  logic                   pick_valid;
  logic [2:0]             pick_idx;
  logic [UART_DATA_W-1:0] pick_byte;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_byte = bus.req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
  end

  // Single FSM with every output registered. Requests are looked at only in
  // IDLE; tx_data_in keeps the granted byte until the following grant. The
  // guard trips once tx_rdy has stayed high for GUARD whole WAIT_BUSY cycles.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state             <= IDLE;
      guard_cnt         <= '0;
      bus.ack           <= '0;
      bus.tx_en_data_in <= 1'b0;
      bus.tx_data_in    <= '0;
      busy              <= 1'b0;
      last_grant        <= 3'(N_REQ - 1);
      guard_err         <= 1'b0;
    end else begin
      bus.ack           <= '0;
      bus.tx_en_data_in <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_rdy && pick_valid) begin
            bus.tx_data_in    <= pick_byte;
            last_grant        <= pick_idx;
            bus.ack           <= N_REQ'(1) << pick_idx;
            bus.tx_en_data_in <= 1'b1;
            busy              <= 1'b1;
            state             <= LAUNCH;
          end
        end
        LAUNCH: begin
          guard_cnt <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.tx_rdy) begin
            state <= WAIT_DONE;
          end else if (guard_cnt == GW'(GUARD - 1)) begin
            guard_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.tx_rdy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
